// File: rtl/lif_neuron_fsm.sv
// lif_neuron_fsm: leaky integrate-and-fire neuron sequenced by a small FSM.
// Each integration step is LEAK (sample current, compute leak) then ACC
// (update the membrane with saturation). Crossing the threshold fires a
// one-cycle spike.
// Optional feature macro: LIF_NEURON_REFRACTORY_EN adds a refractory period
// (REFRAC state plus a down-counter) after every spike. Without it, FIRE
// returns directly to LEAK.
module lif_neuron_fsm #(
  parameter logic signed [17:0] V_TH       = 18'sd4096,
  parameter logic signed [17:0] V_RESET    = 18'sd0,
  parameter int unsigned        LEAK_SHIFT = 4,
  parameter int unsigned        REF_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic signed [17:0] i_in,
  output logic signed [17:0] v_out,
  output logic               spike
);

  // Reject parameter values the datapath cannot honour.
  if (LEAK_SHIFT < 1 || LEAK_SHIFT > 15 || REF_CYCLES < 1) begin : g_paramCheck
    $error("lif_neuron_fsm: LEAK_SHIFT must be 1..15 and REF_CYCLES >= 1");
  end

`ifdef LIF_NEURON_REFRACTORY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEAK   = 3'd1,
    ACC    = 3'd2,
    FIRE   = 3'd3,
    REFRAC = 3'd4
  } state_t;

  // Wide enough to hold REF_CYCLES-1, never narrower than one bit.
  localparam int unsigned REF_W = (REF_CYCLES > 1) ? $clog2(REF_CYCLES) : 1;

  logic [REF_W-1:0] r_refCnt;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEAK = 3'd1,
    ACC  = 3'd2,
    FIRE = 3'd3
  } state_t;
`endif

  state_t             r_state;
  logic signed [17:0] r_iReg;
  logic signed [17:0] r_leakReg;

  logic signed [19:0] w_sum;
  logic signed [17:0] w_sat;

  // Membrane update: three 18-bit terms are sign-extended to 20 bits, which
  // cannot overflow, then clamped back into the 18-bit signed range.
  always_comb begin
    w_sum = {{2{v_out[17]}}, v_out}
          - {{2{r_leakReg[17]}}, r_leakReg}
          + {{2{r_iReg[17]}}, r_iReg};
    if (w_sum > 20'sd131071) begin
      w_sat = 18'sh1FFFF;
    end else if (w_sum < -20'sd131072) begin
      w_sat = 18'sh20000;
    end else begin
      w_sat = w_sum[17:0];
    end
  end

  // Sequencer: state, membrane, spike and the internal pipeline registers.
  // Dropping enable in any active state parks the FSM in IDLE without
  // touching the membrane; re-enabling resumes at LEAK.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      v_out     <= 18'sd0;
      spike     <= 1'b0;
      r_iReg    <= 18'sd0;
      r_leakReg <= 18'sd0;
`ifdef LIF_NEURON_REFRACTORY_EN
      r_refCnt  <= '0;
`endif
    end else begin
      spike <= 1'b0;
      if (r_state != IDLE && !enable) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (enable) begin
              r_state <= LEAK;
            end
          end
          LEAK: begin
            r_iReg    <= i_in;
            r_leakReg <= v_out >>> LEAK_SHIFT;
            r_state   <= ACC;
          end
          ACC: begin
            if (w_sat >= V_TH) begin
              v_out   <= V_RESET;
              spike   <= 1'b1;
              r_state <= FIRE;
            end else begin
              v_out   <= w_sat;
              r_state <= LEAK;
            end
          end
          FIRE: begin
`ifdef LIF_NEURON_REFRACTORY_EN
            r_refCnt <= REF_W'(REF_CYCLES - 1);
            r_state  <= REFRAC;
`else
            r_state  <= LEAK;
`endif
          end
`ifdef LIF_NEURON_REFRACTORY_EN
          REFRAC: begin
            v_out <= V_RESET;
            if (r_refCnt == '0) begin
              r_state <= LEAK;
            end else begin
              r_refCnt <= r_refCnt - 1'b1;
            end
          end
`endif
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/lif_neuron_fsm.md
LIF_NEURON_FSM -- requirements
Module: lif_neuron_fsm

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- V_TH, 18'sd4096, firing threshold, signed.
- V_RESET, 18'sd0, post-spike membrane value, signed.
- LEAK_SHIFT, 4, leak divisor exponent, legal range 1..15.
- REF_CYCLES, 4, refractory length in clocks, minimum 1.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, input, 1, single clock; all state updates on its rising edge.
- reset, input, 1, asynchronous, active-high.
- enable, input, 1, run/hold control.
- i_in, input, 18, signed synaptic current from the current-computation stage.
- v_out, output, 18, signed membrane potential, registered.
- spike, output, 1, registered one-cycle spike pulse to the synapse stage.

REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-high.

Function
REQ-004 States SHALL be IDLE, LEAK, ACC, FIRE and REFRAC.

REQ-005 From IDLE with enable=1, the next state SHALL be LEAK; with enable=0, the block stays in IDLE and v_out holds.

REQ-006 In LEAK, the block SHALL register i_reg <= i_in and leak_reg <= v_out >>> LEAK_SHIFT (arithmetic shift), then go to ACC.

REQ-007 In ACC, the block SHALL compute sum = v_out - leak_reg + i_reg in at least 20 bits and saturate it to [-131072, 131071].

REQ-008 ACC outcome:
- If the saturated sum >= V_TH (signed compare): v_out <= V_RESET, next state FIRE.
- Otherwise: v_out <= saturated sum, next state LEAK.

REQ-009 spike SHALL be 1 exactly during the single cycle the state is FIRE, and 0 at all other times.

REQ-010 From FIRE, the next state SHALL be REFRAC with ref_cnt <= REF_CYCLES-1 when the macro is defined, or LEAK when it is not (see REQ-017/018).

REQ-011 In REFRAC:
- v_out SHALL hold V_RESET and i_in SHALL be ignored.
- ref_cnt SHALL decrement each cycle.
- When ref_cnt = 0, the next state SHALL be LEAK.

REQ-012 Without a spike, one integration step SHALL take 2 clocks (LEAK+ACC). With a spike, it takes 3 + REF_CYCLES clocks before the next LEAK.

REQ-013 enable=0 in any non-IDLE state SHALL force the next state to IDLE.
- No v_out update occurs on that edge.
- spike already asserted in FIRE completes its cycle.
- Re-enable resumes at LEAK with v_out preserved.

REQ-014 i_in SHALL be sampled only in LEAK; changes in any other state have no effect.

Reset
REQ-015 While reset=1, regardless of clock:
- state = IDLE
- v_out = 0
- spike = 0
- ref_cnt = 0
- i_reg = 0
- leak_reg = 0

REQ-016 Reset asserted mid-operation (any state, including FIRE or REFRAC) SHALL abort immediately. After release, the block SHALL restart from IDLE.

Configuration
REQ-017 Macro LIF_NEURON_REFRACTORY_EN defined: the REFRAC state and ref_cnt SHALL be implemented per REQ-010/011.

REQ-018 Macro LIF_NEURON_REFRACTORY_EN undefined: the REFRAC state and ref_cnt SHALL not exist, FIRE SHALL go directly to LEAK, and REF_CYCLES SHALL be unused.

Verification
REQ-019 Default parameters, macro defined, enable=1, i_in=1024 constant -> v_out after successive ACC cycles = 1024, 1984, 2884, 3728; 5th ACC gives 4519 >= 4096 -> v_out=0, spike=1 for one cycle, then 4 REFRAC cycles, then LEAK.

REQ-020 During REFRAC, i_in switched to 20000 -> v_out stays 0 and spike stays 0 until REFRAC exits; the first LEAK after exit samples 20000.

REQ-021 i_in=-131072 constant from v_out=0 -> v_out=-131072 after the first ACC; on the next ACC (sum -253952) v_out clamps at -131072 with no wrap.

REQ-022 enable dropped in LEAK with v_out=2884 -> IDLE next cycle, v_out=2884 held for 10 cycles; re-enable -> LEAK, and the next ACC yields 2884 - 180 + i_in.

REQ-023 reset pulsed asynchronously between clock edges during REFRAC -> v_out=0, spike=0, state IDLE without waiting for a clock edge; after release with enable=1, LEAK follows on the next edge.

REQ-024 Macro undefined, same stimulus as REQ-019 -> the FIRE cycle is immediately followed by LEAK, and the next ACC yields v_out=1024.
